alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Registered output stage directly downstream of NBit_ALU.
- Captures each N-bit ALU result together with the opcode that produced it, using a valid/ready handshake.
- Holds results in a 2-entry skid buffer, so in_ready is a flop output with no combinational path from out_ready.
- Keeps a wrapping count of results delivered downstream.

Parameters:
- N, 4: data width; must match the upstream ALU N.
- OPCODE, 0: opcode of the upstream ALU instance (0..3, 2-bit); reported on out_op.
- CNT_W, 8: width of the delivered-result counter.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_data  in  N  ALU result (NBit_ALU output)
- in_valid  in  1  in_data valid this cycle
- in_ready  out  1  stage can accept; driven straight from state flops
- out_data  out  N  head-of-buffer result
- out_op  out  2  opcode tag for out_data (constant OPCODE)
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accepts
- out_count  out  CNT_W  number of results delivered, wraps
- out_zero  out  1  present only with ALU_ZERO_FLAG_EN

Behaviour:
- Reset (asynchronous, active-high, acts immediately):
  - state=EMPTY; in_ready=1; out_valid=0; out_data=0; out_count=0; out_zero=0; both slots cleared.
  - Reset mid-transfer discards buffered results; no partial output.
- Transfer events:
  - acc = in_valid & in_ready.
  - dlv = out_valid & out_ready.
  - Both are sampled at the rising clk edge.
- States, with slot0 = head and slot1 = skid:
  - EMPTY: out_valid=0, in_ready=1. acc -> slot0=in_data, go ONE.
  - ONE: out_valid=1, in_ready=1.
    - acc & dlv -> slot0=in_data, stay ONE.
    - acc & !dlv -> slot1=in_data, go TWO.
    - !acc & dlv -> go EMPTY.
    - neither -> hold.
  - TWO: out_valid=1, in_ready=0.
    - dlv -> slot0<=slot1, go ONE.
    - Otherwise hold.
    - in_valid is ignored; no acc is possible in TWO.
- Timing and ordering:
  - Latency: result accepted at edge k is on out_data after edge k when the buffer was EMPTY.
  - Strict FIFO order; no drops; no duplicates.
- Output stability: while out_valid=1 and out_ready=0, out_data and out_op hold stable.
- Upstream protocol: may deassert in_valid freely; the ALU is combinational, so in_data is sampled only on acc.
- Counter:
  - out_count increments by 1 on each dlv.
  - Wraps 2^CNT_W-1 -> 0 with no flag.
  - Unaffected by acc.
- Other rules:
  - out_op is constant OPCODE[1:0]; it is gated to 0 while out_valid=0.
  - No arithmetic on data; widths pass through unchanged.
- Boundaries:
  - Simultaneous acc and dlv in ONE keeps throughput at 1 result/cycle.
  - in_ready reaches 0 only in TWO.
  - out_ready held low forever -> holds 2 results, then stalls upstream.

Optional Feature:
- Macro: ALU_ZERO_FLAG_EN.
- Defined:
  - Adds out_zero.
  - A per-slot flag is registered on acc as (in_data==0) and moves with its slot.
  - out_zero = head flag while out_valid=1, else 0.
  - Reset value 0.
- Undefined: port and flag flops absent; all other behaviour identical.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants OP_ADD=0, OP_SUB=1, OP_AND=2, OP_XOR=3 (XOR=3 matches existing ALU usage).
  - 2-bit opcode typedef.
  - State encoding EMPTY/ONE/TWO.
- One sub-module, alu_result_slot: N-bit data register plus optional zero flag, with load enable and async clear; instantiated twice.
- The state machine and counter stay in the top module.

Test Plan:
- Reset: assert rst mid-cycle with 2 results buffered -> out_valid=0, in_ready=1, out_count=0, out_data=0 immediately, before the next edge.
- Single pass, N=4, OPCODE=3: in_data=4'hA, in_valid=1 for 1 cycle, out_ready=1 -> next cycle out_data=4'hA, out_op=2'd3, out_valid=1; count becomes 1.
- Backpressure: out_ready=0, push 4'h3 then 4'h5 -> in_ready=0 after the second push. Raise out_ready -> outputs 4'h3 then 4'h5 in order; in_ready returns 1 after the first delivery.
- Streaming: out_ready=1, 100 random XOR results (in0^in1) pushed back-to-back -> no stall, outputs match the scoreboard in order, out_count=100.
- Counter wrap, CNT_W=8: deliver 257 results -> out_count=1.
- With ALU_ZERO_FLAG_EN: push 4'h0 then 4'h7 -> out_zero=1 with 4'h0, then 0 with 4'h7.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode and result-stage state definitions for the ALU result path.
package alu_pkg;
  typedef logic [1:0] opcode_t;

  localparam opcode_t OP_ADD = 2'd0;
  localparam opcode_t OP_SUB = 2'd1;
  localparam opcode_t OP_AND = 2'd2;
  localparam opcode_t OP_XOR = 2'd3;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_ONE   = 2'd1;
  localparam logic [1:0] ST_TWO   = 2'd2;
endpackage

// File: rtl/alu_result_slot.sv
// One skid-buffer entry: N-bit result register with load enable and async clear.
// With ALU_ZERO_FLAG_EN defined, a zero flag travels alongside the data.
module alu_result_slot
  import alu_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [N-1:0] data_i,
`ifdef ALU_ZERO_FLAG_EN
  input  logic         zero_i,
  output logic         zero_o,
`endif
  output logic [N-1:0] data_o
);
  logic [N-1:0] data_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         data_q <= '0;
    else if (load_i) data_q <= data_i;
  end

  assign data_o = data_q;

`ifdef ALU_ZERO_FLAG_EN
  logic zero_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         zero_q <= 1'b0;
    else if (load_i) zero_q <= zero_i;
  end

  assign zero_o = zero_q;
`endif
endmodule

// File: rtl/alu_result_stage.sv
// Registered 2-entry skid buffer behind NBit_ALU with a wrapping delivery counter.
// Optional out_zero flag is enabled by defining ALU_ZERO_FLAG_EN.
//   state    | meaning
//   EMPTY    | no result held, out_valid=0
//   ONE      | head slot valid, can still accept
//   TWO      | head and skid slots valid, upstream stalled
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int N      = 4,
  parameter int OPCODE = 0,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N-1:0]     in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [N-1:0]     out_data,
  output logic [1:0]       out_op,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef ALU_ZERO_FLAG_EN
  output logic             out_zero,
`endif
  output logic [CNT_W-1:0] out_count
);
  localparam opcode_t OP_TAG = opcode_t'(OPCODE);

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             acc, dlv, ld0, ld1;
  logic [N-1:0]     s0_data, s1_data, s0_in;

  // Handshake outputs decode state flops only; no path from out_ready.
  assign in_ready  = (state_q != ST_TWO);
  assign out_valid = (state_q != ST_EMPTY);
  assign acc       = in_valid & in_ready;
  assign dlv       = out_valid & out_ready;

  always_comb begin
    state_d = state_q;
    ld0     = 1'b0;
    ld1     = 1'b0;
    case (state_q)
      ST_EMPTY: if (acc) begin ld0 = 1'b1; state_d = ST_ONE; end
      ST_ONE: begin
        if (acc && dlv)       ld0 = 1'b1;
        else if (acc)         begin ld1 = 1'b1; state_d = ST_TWO; end
        else if (dlv)         state_d = ST_EMPTY;
      end
      ST_TWO: if (dlv) begin ld0 = 1'b1; state_d = ST_ONE; end
      default: state_d = ST_EMPTY;
    endcase
  end

  assign s0_in = (state_q == ST_TWO) ? s1_data : in_data;
  assign cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, dlv};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_EMPTY;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef ALU_ZERO_FLAG_EN
  logic z0, z1, z0_in, zin;
  assign zin   = (in_data == '0);
  assign z0_in = (state_q == ST_TWO) ? z1 : zin;
`endif

  alu_result_slot #(.N(N)) u_slot0 (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld0),
    .data_i (s0_in),
`ifdef ALU_ZERO_FLAG_EN
    .zero_i (z0_in),
    .zero_o (z0),
`endif
    .data_o (s0_data)
  );

  alu_result_slot #(.N(N)) u_slot1 (
    .clk    (clk),
    .rst    (rst),
    .load_i (ld1),
    .data_i (in_data),
`ifdef ALU_ZERO_FLAG_EN
    .zero_i (zin),
    .zero_o (z1),
`endif
    .data_o (s1_data)
  );

  assign out_data  = s0_data;
  assign out_op    = out_valid ? OP_TAG : 2'd0;
  assign out_count = cnt_q;
`ifdef ALU_ZERO_FLAG_EN
  assign out_zero  = out_valid & z0;
`endif
endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: directed cases plus random traffic
// checked against a FIFO-occupancy model.
module tb_alu_result_stage;
  localparam int N     = 4;
  localparam int OPC   = 3;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic [N-1:0]     in_data;
  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     out_data;
  logic [1:0]       out_op;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_count;
`ifdef ALU_ZERO_FLAG_EN
  logic             out_zero;
`endif

  int total = 0;
  int bad   = 0;
  logic [N-1:0]     sb[$];
  logic [CNT_W-1:0] mcnt = '0;
  int               n_acc = 0;

  alu_result_stage #(.N(N), .OPCODE(OPC), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_op    (out_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
`ifdef ALU_ZERO_FLAG_EN
    .out_zero  (out_zero),
`endif
    .out_count (out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int guard = 0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    while ((out_valid || sb.size() != 0) && guard < 50) begin
      step();
      guard++;
    end
    chk("drain_timeout", guard < 50, 1);
  endtask

  // Monitor: output side is checked against the queue first, then any
  // acceptance happening at the coming edge is recorded.
  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      mcnt  = '0;
      n_acc = 0;
    end else begin
      chk("count", out_count, mcnt);
      chk("valid", out_valid, sb.size() != 0);
      chk("in_ready", in_ready, sb.size() < 2);
      if (out_valid) begin
        chk("op", out_op, OPC);
        if (sb.size() != 0) begin
          chk("data", out_data, sb[0]);
`ifdef ALU_ZERO_FLAG_EN
          chk("zero", out_zero, sb[0] == 0);
`endif
        end
        if (out_ready) begin
          if (sb.size() != 0) void'(sb.pop_front());
          mcnt = mcnt + 1'b1;
        end
      end else begin
        chk("op_idle", out_op, 0);
`ifdef ALU_ZERO_FLAG_EN
        chk("zero_idle", out_zero, 0);
`endif
      end
      if (in_valid && in_ready) begin
        sb.push_back(in_data);
        n_acc++;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

  initial begin
    logic [N-1:0] a, b;
    int guard;
    rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    #2;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_count", out_count, 0);
    chk("rst_data", out_data, 0);
    chk("rst_op", out_op, 0);
    step(); step();
    rst = 1'b0;

    // single pass
    in_data = 4'hA; in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    chk("single_valid", out_valid, 1);
    chk("single_data", out_data, 4'hA);
    chk("single_op", out_op, 2'd3);
    step();
    chk("single_count", out_count, 1);
    chk("single_empty", out_valid, 0);

    // backpressure
    out_ready = 1'b0;
    in_data = 4'h3; in_valid = 1'b1; step();
    in_data = 4'h5; step();
    in_valid = 1'b0;
    chk("bp_full", in_ready, 0);
    step(); step();
    chk("bp_stall", in_ready, 0);
    chk("bp_hold", out_data, 4'h3);
    out_ready = 1'b1;
    step();
    chk("bp_reopen", in_ready, 1);
    chk("bp_second", out_data, 4'h5);
    step();
    chk("bp_done", out_valid, 0);
    chk("bp_count", out_count, 3);

    // reset with two results buffered
    out_ready = 1'b0;
    in_data = 4'h9; in_valid = 1'b1; step();
    in_data = 4'hC; step();
    in_valid = 1'b0;
    chk("pre_rst_full", in_ready, 0);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_count", out_count, 0);
    chk("mid_rst_data", out_data, 0);
    step();
    rst = 1'b0;
    step();

    // streaming XOR results back-to-back
    out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      a = N'($urandom); b = N'($urandom);
      in_data = a ^ b; in_valid = 1'b1;
      chk("stream_ready", in_ready, 1);
      step();
    end
    drain();
    chk("stream_count", out_count, 100);

    // random traffic up to 257 deliveries total
    guard = 0;
    while (n_acc < 257 && guard < 5000) begin
      in_valid  = $urandom_range(0, 1) == 1;
      in_data   = N'($urandom);
      out_ready = $urandom_range(0, 3) != 0;
      step();
      guard++;
    end
    chk("random_timeout", guard < 5000, 1);
    drain();
    chk("wrap_count", out_count, 1);

`ifdef ALU_ZERO_FLAG_EN
    out_ready = 1'b0;
    in_data = 4'h0; in_valid = 1'b1; step();
    in_data = 4'h7; step();
    in_valid = 1'b0;
    chk("zflag_head", out_zero, 1);
    chk("zflag_data0", out_data, 4'h0);
    out_ready = 1'b1;
    step();
    chk("zflag_next", out_zero, 0);
    chk("zflag_data7", out_data, 4'h7);
    drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
